div_unit: RTL and testbench

- Sequential signed 32-bit integer divider in the CPU execute stage, used for the div instruction.
- Sits alongside the combinational shifters; internally it is a shift-subtract datapath, one quotient bit per cycle.
- The core stalls on busy and writes back data_result on data_resultRDY.

---
 rtl/div_unit.sv | 108 ++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Sequential signed 32-bit divider for the execute stage: restoring shift-subtract,
// one quotient bit per clock, with a fixed 33-edge latency from start to result.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] data_operandA,
    input  logic signed [WIDTH-1:0] data_operandB,
    input  logic                    ctrl_DIV,
    output logic signed [WIDTH-1:0] data_result,
    output logic                    data_exception,
    output logic                    data_resultRDY,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t             state;
    logic [5:0]         count;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   abs_b;
    logic               sign_q;
    logic               div_zero;
    logic               ovf;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    // The most negative value maps onto itself, which read unsigned is exactly 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        magnitude = v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                           input logic [WIDTH-1:0] mag);
        apply_sign = neg ? (~mag + 1'b1) : mag;
    endfunction

    // Trial subtract in WIDTH+1 bits; the top bit of diff is the borrow, i.e. rem < |B|.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, abs_b};
        rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            rem            <= '0;
            quo            <= '0;
            abs_b          <= '0;
            sign_q         <= 1'b0;
            div_zero       <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            // A start in any state wins, so a pulse while busy silently aborts the old op.
            if (ctrl_DIV) begin
                quo      <= magnitude(data_operandA);
                abs_b    <= magnitude(data_operandB);
                sign_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_zero <= (data_operandB == '0);
                ovf      <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                            (data_operandB == '1);
                rem      <= '0;
                count    <= '0;
                busy     <= 1'b1;
                state    <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count + 6'd1;
                        if (count == LAST_STEP)
                            state <= FIX;
                    end
                    FIX: begin
                        if (div_zero || ovf) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= apply_sign(sign_q, quo);
                            data_exception <= 1'b0;
                        end
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus back-to-back random
// divisions compared against a plain signed-division reference model.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    localparam int MIN_INT = 32'h80000000;

    div_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division, with divide-by-zero and MIN/-1 flagged.
    function automatic void ref_div(input int a, input int b, output int q, output bit e);
        if (b == 0 || (a == MIN_INT && b == -1)) begin
            q = 0;
            e = 1'b1;
        end else begin
            q = a / b;
            e = 1'b0;
        end
    endfunction

    // Called just after a negedge; leaves the bench just after the start edge.
    task automatic start_op(input int a, input int b);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Returns edges from start to the edge that raised RDY (-1 on timeout), and busy samples seen.
    task automatic wait_rdy(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (data_resultRDY) begin
                lat = n - 1;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic do_op(input int a, input int b, input string tag);
        int lat, busy_n, q;
        bit e;
        start_op(a, b);
        wait_rdy(lat, busy_n);
        ref_div(a, b, q, e);
        check({tag, "_lat"}, lat, 33);
        check({tag, "_q"}, data_result, q);
        check({tag, "_exc"}, {31'b0, data_exception}, {31'b0, e});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int lat, busy_n, rdy_n, a, b;
        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("rst_result", data_result, 0);
        check("rst_exc", {31'b0, data_exception}, 0);
        check("rst_rdy", {31'b0, data_resultRDY}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        @(negedge clock);
        reset = 1'b0;

        // Basic op with busy-window and hold checks
        start_op(100, 7);
        wait_rdy(lat, busy_n);
        check("basic_lat", lat, 33);
        check("basic_busy_cycles", busy_n, 33);
        check("basic_busy_rdy", {31'b0, busy}, 0);
        check("basic_q", data_result, 14);
        check("basic_exc", {31'b0, data_exception}, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("hold_rdy", {31'b0, data_resultRDY}, 0);
            check("hold_q", data_result, 14);
        end

        do_op(-100, 7, "neg_a");
        do_op(100, -7, "neg_b");
        do_op(-100, -7, "neg_ab");
        do_op(7, -100, "trunc0");
        do_op(MIN_INT, 2, "min_div2");
        do_op(MIN_INT, 1, "min_div1");
        do_op(1234, 0, "div_zero");
        do_op(MIN_INT, -1, "ovf");
        do_op(9, 3, "after_exc");

        // Restart: second pulse at edge 10 of the first op
        start_op(1000, 3);
        repeat (10) @(negedge clock);
        start_op(50, 5);
        wait_rdy(lat, busy_n);
        check("restart_lat", lat, 33);
        check("restart_q", data_result, 10);
        rdy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_n++;
        end
        check("restart_extra_rdy", rdy_n, 0);

        // Asynchronous reset between edges during an op
        start_op(999, 9);
        repeat (20) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_result", data_result, 0);
        check("midrst_exc", {31'b0, data_exception}, 0);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_rdy", {31'b0, data_resultRDY}, 0);
        #1 reset = 1'b0;
        rdy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY) rdy_n++;
        end
        check("midrst_no_rdy", rdy_n, 0);
        do_op(8, 2, "after_rst");

        // Random back-to-back: each new start is issued in the RDY cycle of the previous op
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 0;
                1: begin a = MIN_INT; b = -1; end
                2: a = MIN_INT;
                3, 4, 5: begin
                    b = $urandom_range(1, 1000);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                default: ;
            endcase
            do_op(a, b, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
